// File: rtl/draw_pkg.sv
// Shared definitions for the draw-position arbiter: screen geometry,
// coordinate width, source identifiers and the FSM state encoding.
package draw_pkg;

  localparam int COORD_W  = 12;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ARB        = 2'd1,
    ST_SEND       = 2'd2,
    ST_WAIT_FRAME = 2'd3
  } state_e;

endpackage

// File: rtl/draw_pos_arbiter.sv
// Frame-scheduled arbiter between two position sources (local mouse A,
// remote player B). Each source is served at most once per frame, in
// round-robin order; captured coordinates are clamped to the screen and
// held on a valid/ready interface until the draw stage accepts them.
module draw_pos_arbiter
  import draw_pkg::*;
#(
  parameter int unsigned X_MAX = SCREEN_W - 1,
  parameter int unsigned Y_MAX = SCREEN_H - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               req_a,
  input  logic [COORD_W-1:0] xpos_a_in,
  input  logic [COORD_W-1:0] ypos_a_in,
  input  logic               req_b,
  input  logic [COORD_W-1:0] xpos_b_in,
  input  logic [COORD_W-1:0] ypos_b_in,
  output logic               gnt_a,
  output logic               gnt_b,
  input  logic               ready_in,
  output logic               valid_out,
  output logic               src_out,
  output logic [COORD_W-1:0] xpos_out,
  output logic [COORD_W-1:0] ypos_out,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  state_e             state_q, state_d;
  logic               served_a_q, served_a_d;
  logic               served_b_q, served_b_d;
  logic               ptr_q, ptr_d;
  logic               pending_q, pending_d;
  logic               valid_q, valid_d;
  logic               src_q, src_d;
  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               frame_done_q, frame_done_d;

  logic               elig_a, elig_b;
  logic               pick_src;
  logic               grant;
  logic               xfer_done;
  logic               pending_now;
  logic               both_served;
  logic [COORD_W-1:0] xpos_sel, ypos_sel;
  logic [COORD_W-1:0] xpos_clamped, ypos_clamped;

  // Arbitration decision: eligible sources, round-robin pick, handshake.
  always_comb begin
    elig_a = req_a & ~served_a_q;
    elig_b = req_b & ~served_b_q;
    if (elig_a && elig_b) begin
      pick_src = ptr_q;
    end else if (elig_b) begin
      pick_src = SRC_B;
    end else begin
      pick_src = SRC_A;
    end
    // A frame_start seen in ARB only restarts the frame; granting waits a cycle.
    grant       = (state_q == ST_ARB) && !frame_start && (elig_a || elig_b);
    xfer_done   = (state_q == ST_SEND) && valid_q && ready_in;
    pending_now = pending_q || frame_start;
    both_served = served_a_q && served_b_q;
  end

  // Capture path: select the winner's coordinates and clamp to the screen.
  always_comb begin
    xpos_sel     = (pick_src == SRC_B) ? xpos_b_in : xpos_a_in;
    ypos_sel     = (pick_src == SRC_B) ? ypos_b_in : ypos_a_in;
    xpos_clamped = (xpos_sel > X_LIM) ? X_LIM : xpos_sel;
    ypos_clamped = (ypos_sel > Y_LIM) ? Y_LIM : ypos_sel;
  end

  // Next-state logic of the scheduling FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (grant) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (xfer_done) begin
          state_d = (!pending_now && both_served) ? ST_WAIT_FRAME : ST_ARB;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) state_d = ST_ARB;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: served flags, pointer, held transfer, pulses.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    served_a_d   = served_a_q;
    served_b_d   = served_b_q;
    ptr_d        = ptr_q;
    pending_d    = pending_q;
    valid_d      = valid_q;
    src_d        = src_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WAIT_FRAME: begin
        if (frame_start) begin
          served_a_d = 1'b0;
          served_b_d = 1'b0;
        end
      end
      ST_ARB: begin
        if (frame_start) begin
          served_a_d = 1'b0;
          served_b_d = 1'b0;
        end else if (grant) begin
          valid_d = 1'b1;
          src_d   = pick_src;
          xpos_d  = xpos_clamped;
          ypos_d  = ypos_clamped;
          if (pick_src == SRC_B) begin
            gnt_b_d    = 1'b1;
            served_b_d = 1'b1;
          end else begin
            gnt_a_d    = 1'b1;
            served_a_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (frame_start) pending_d = 1'b1;
        if (xfer_done) begin
          valid_d = 1'b0;
          ptr_d   = ~src_q;
          if (pending_now) begin
            // A new frame opened while this transfer was in flight.
            served_a_d = 1'b0;
            served_b_d = 1'b0;
            pending_d  = 1'b0;
          end else if (both_served) begin
            frame_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset drops any held transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      served_a_q   <= 1'b0;
      served_b_q   <= 1'b0;
      ptr_q        <= SRC_A;
      pending_q    <= 1'b0;
      valid_q      <= 1'b0;
      src_q        <= SRC_A;
      xpos_q       <= '0;
      ypos_q       <= '0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      served_a_q   <= served_a_d;
      served_b_q   <= served_b_d;
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      valid_q      <= valid_d;
      src_q        <= src_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign valid_out  = valid_q;
  assign src_out    = src_q;
  assign xpos_out   = xpos_q;
  assign ypos_out   = ypos_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_draw_pos_arbiter.sv
// Self-checking bench for draw_pos_arbiter: directed frame sequences, a
// clamp vector table and randomized frames against a transaction model.
module tb_draw_pos_arbiter;
  import draw_pkg::*;

  localparam int XM = 799;
  localparam int YM = 599;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        req_a, req_b, ready_in;
  logic [11:0] xpos_a_in, ypos_a_in, xpos_b_in, ypos_b_in;
  logic        gnt_a, gnt_b, valid_out, src_out, frame_done;
  logic [11:0] xpos_out, ypos_out;

  always #5 clk = ~clk;

  draw_pos_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .req_a      (req_a),
    .xpos_a_in  (xpos_a_in),
    .ypos_a_in  (ypos_a_in),
    .req_b      (req_b),
    .xpos_b_in  (xpos_b_in),
    .ypos_b_in  (ypos_b_in),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .src_out    (src_out),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .frame_done (frame_done)
  );

  typedef struct {
    logic        src;
    logic [11:0] x;
    logic [11:0] y;
  } xfer_t;

  typedef struct {
    logic [11:0] x_in;
    logic [11:0] y_in;
    logic [11:0] x_exp;
    logic [11:0] y_exp;
  } clamp_vec_t;

  xfer_t       xfer_q[$];
  xfer_t       exp_q[$];
  int unsigned gnt_cyc[$];
  int unsigned cyc = 0;
  int unsigned fd_cnt, ga_cnt, gb_cnt;
  int          checks = 0;
  int          failures = 0;
  bit          rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: completed transfers, grant pulses and frame_done pulses.
  always @(negedge clk) begin
    xfer_t t;
    if (valid_out && ready_in) begin
      t.src = src_out;
      t.x   = xpos_out;
      t.y   = ypos_out;
      xfer_q.push_back(t);
    end
    if (frame_done) fd_cnt++;
    if (gnt_a) begin ga_cnt++; gnt_cyc.push_back(cyc); end
    if (gnt_b) begin gb_cnt++; gnt_cyc.push_back(cyc); end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_mon();
    xfer_q.delete();
    gnt_cyc.delete();
    fd_cnt = 0;
    ga_cnt = 0;
    gb_cnt = 0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    for (int i = 0; i < budget && xfer_q.size() < n; i++) tick();
    tick();
    tick();
    check(name, xfer_q.size(), n);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !valid_out; i++) tick();
    check(name, valid_out, 1);
  endtask

  task automatic check_xfer(input int idx, input logic src, input logic [11:0] x,
                            input logic [11:0] y, input string name);
    if (idx < xfer_q.size()) begin
      check({name, "_src"}, xfer_q[idx].src, src);
      check({name, "_x"}, xfer_q[idx].x, x);
      check({name, "_y"}, xfer_q[idx].y, y);
    end else begin
      check({name, "_missing"}, xfer_q.size(), idx + 1);
    end
  endtask

  function automatic logic [11:0] clampv(input logic [11:0] v, input int m);
    return (int'(v) > m) ? 12'(m) : v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  clamp_vec_t vecs[6];

  initial begin
    logic        ra, rb, mptr;
    logic [11:0] ax, ay, bx, by;
    xfer_t       e;

    rst_n = 1'b0;
    frame_start = 1'b0;
    req_a = 1'b0; req_b = 1'b0; ready_in = 1'b1;
    xpos_a_in = '0; ypos_a_in = '0; xpos_b_in = '0; ypos_b_in = '0;
    clear_mon();

    vecs[0] = '{12'd1000, 12'd4095, 12'd799, 12'd599};
    vecs[1] = '{12'd799,  12'd599,  12'd799, 12'd599};
    vecs[2] = '{12'd800,  12'd600,  12'd799, 12'd599};
    vecs[3] = '{12'd0,    12'd0,    12'd0,   12'd0};
    vecs[4] = '{12'd123,  12'd598,  12'd123, 12'd598};
    vecs[5] = '{12'd4095, 12'd0,    12'd799, 12'd0};

    // Reset state.
    tick();
    tick();
    check("rst_valid", valid_out, 0);
    check("rst_gnt", {gnt_a, gnt_b}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_src", src_out, 0);
    check("rst_xy", {xpos_out, ypos_out}, 0);

    // No grant after reset release until frame_start.
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    xpos_a_in = 12'd100; ypos_a_in = 12'd200;
    xpos_b_in = 12'd300; ypos_b_in = 12'd400;
    repeat (6) tick();
    check("no_gnt_before_frame", ga_cnt + gb_cnt, 0);

    // Basic frame: A then B, frame_done, grant spacing of 2.
    clear_mon();
    pulse_frame();
    wait_xfers(2, 40, "basic_count");
    check_xfer(0, SRC_A, 12'd100, 12'd200, "basic_first");
    check_xfer(1, SRC_B, 12'd300, 12'd400, "basic_second");
    check("basic_frame_done", fd_cnt, 1);
    if (gnt_cyc.size() == 2) check("grant_spacing", gnt_cyc[1] - gnt_cyc[0], 2);
    else check("grant_spacing_count", gnt_cyc.size(), 2);
    repeat (10) tick();
    check("wait_frame_no_grant", ga_cnt + gb_cnt, 2);
    pulse_frame();
    wait_xfers(4, 40, "frame2_count");
    check_xfer(2, SRC_A, 12'd100, 12'd200, "frame2_first");
    check_xfer(3, SRC_B, 12'd300, 12'd400, "frame2_second");
    check("frame2_done", fd_cnt, 2);

    // Clamp vectors, one A-only frame each.
    req_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      req_a = 1'b1;
      xpos_a_in = vecs[i].x_in;
      ypos_a_in = vecs[i].y_in;
      pulse_frame();
      wait_xfers(1, 40, $sformatf("clamp%0d_count", i));
      check_xfer(0, SRC_A, vecs[i].x_exp, vecs[i].y_exp, $sformatf("clamp%0d", i));
      check($sformatf("clamp%0d_no_done", i), fd_cnt, 0);
      req_a = 1'b0;
    end

    // Backpressure: held transfer stays stable while inputs wander.
    clear_mon();
    ready_in = 1'b0;
    req_a = 1'b1;
    xpos_a_in = 12'd10; ypos_a_in = 12'd20;
    pulse_frame();
    wait_valid("bp_valid_up");
    for (int i = 0; i < 10; i++) begin
      xpos_a_in = 12'($urandom);
      ypos_a_in = 12'($urandom);
      req_a = 1'(i);
      tick();
      check($sformatf("bp_hold%0d", i), {valid_out, src_out, xpos_out, ypos_out},
            {1'b1, 1'b0, 12'd10, 12'd20});
    end
    ready_in = 1'b1;
    req_a = 1'b0;
    tick();
    check("bp_valid_drop", valid_out, 0);
    repeat (4) tick();
    check("bp_single_xfer", xfer_q.size(), 1);
    check("bp_single_gnt", ga_cnt + gb_cnt, 1);

    // frame_start during SEND: transfer finishes, both sources served again.
    clear_mon();
    req_a = 1'b1; req_b = 1'b1;
    xpos_a_in = 12'd1; ypos_a_in = 12'd2;
    xpos_b_in = 12'd3; ypos_b_in = 12'd4;
    ready_in = 1'b0;
    pulse_frame();
    wait_valid("mid_valid_up");
    pulse_frame();
    tick();
    ready_in = 1'b1;
    wait_xfers(3, 40, "mid_count");
    check_xfer(0, SRC_B, 12'd3, 12'd4, "mid_first");
    check_xfer(1, SRC_A, 12'd1, 12'd2, "mid_second");
    check_xfer(2, SRC_B, 12'd3, 12'd4, "mid_third");
    check("mid_frame_done", fd_cnt, 1);

    // Round-robin across frames: A-only, then B-only, then both -> A first.
    clear_mon();
    req_a = 1'b1; req_b = 1'b0;
    pulse_frame();
    wait_xfers(1, 40, "rr_f0_count");
    req_a = 1'b0; req_b = 1'b1;
    pulse_frame();
    wait_xfers(2, 40, "rr_f1_count");
    check("rr_f1_src", xfer_q.size() > 1 ? xfer_q[1].src : 1'bx, SRC_B);
    req_a = 1'b1;
    pulse_frame();
    wait_xfers(4, 40, "rr_f2_count");
    check("rr_f2_first", xfer_q.size() > 2 ? xfer_q[2].src : 1'bx, SRC_A);
    check("rr_f2_second", xfer_q.size() > 3 ? xfer_q[3].src : 1'bx, SRC_B);

    // Reset mid-SEND drops valid immediately; no grant until frame_start.
    clear_mon();
    req_a = 1'b1; req_b = 1'b0;
    ready_in = 1'b0;
    pulse_frame();
    wait_valid("rst_mid_valid_up");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_async", valid_out, 0);
    check("rst_mid_xy", {xpos_out, ypos_out}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
    ready_in = 1'b1;
    repeat (8) tick();
    check("rst_mid_no_gnt", ga_cnt + gb_cnt, 0);
    check("rst_mid_no_xfer", xfer_q.size(), 0);
    pulse_frame();
    wait_xfers(1, 40, "rst_mid_after_frame");

    // Randomized frames against a transaction-level round-robin model.
    do_reset();
    req_a = 1'b0; req_b = 1'b0;
    mptr = SRC_A;
    for (int f = 0; f < 30; f++) begin
      clear_mon();
      exp_q.delete();
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ax = 12'($urandom); ay = 12'($urandom);
      bx = 12'($urandom); by = 12'($urandom);
      // Serve requesters starting at the pointer; pointer then names the other one.
      for (int k = 0; k < 2; k++) begin
        logic s;
        s = (k == 0) ? mptr : ~mptr;
        if ((s == SRC_A && ra) || (s == SRC_B && rb)) begin
          e.src = s;
          e.x = (s == SRC_A) ? clampv(ax, XM) : clampv(bx, XM);
          e.y = (s == SRC_A) ? clampv(ay, YM) : clampv(by, YM);
          exp_q.push_back(e);
        end
      end
      if (exp_q.size() > 0) mptr = ~exp_q[exp_q.size() - 1].src;
      req_a = ra; req_b = rb;
      xpos_a_in = ax; ypos_a_in = ay;
      xpos_b_in = bx; ypos_b_in = by;
      rnd_ready = 1'b1;
      pulse_frame();
      wait_xfers(exp_q.size(), 200, $sformatf("rnd%0d_count", f));
      rnd_ready = 1'b0;
      ready_in = 1'b1;
      for (int k = 0; k < exp_q.size(); k++)
        check_xfer(k, exp_q[k].src, exp_q[k].x, exp_q[k].y, $sformatf("rnd%0d_x%0d", f, k));
      check($sformatf("rnd%0d_done", f), fd_cnt, (ra && rb) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
